// File: rtl/draw_background_dyn_if.sv
// VGA timing/pixel bundle shared between pipeline stages.
// Upstream drives through modport "in"; this stage drives through modport "out".
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_background_dyn.sv
// Background painter with a slow day/night colour cycle.
// Sky, grass and a fence are drawn from the incoming VGA coordinates.
// Sky and grass colours fade one 4-bit step per channel per colour step.
// Optional macro BG_STARS_EN adds a fixed star pattern to the night sky.
//
// state | meaning
// DAY   | day colours held for HOLD_STEPS colour steps
// DUSK  | fading toward SKY_NIGHT / GRASS_NIGHT
// NIGHT | night colours held for HOLD_STEPS colour steps
// DAWN  | fading toward SKY_DAY / GRASS_DAY
module draw_background_dyn #(
    parameter int          FENCE_X0        = 497,
    parameter int          FENCE_X1        = 527,
    parameter int          FENCE_Y0        = 384,
    parameter int          FENCE_Y1        = 743,
    parameter int          HORIZON_Y       = 668,
    parameter logic [11:0] SKY_DAY         = 12'hadf,
    parameter logic [11:0] SKY_NIGHT       = 12'h113,
    parameter logic [11:0] GRASS_DAY       = 12'h5c5,
    parameter logic [11:0] GRASS_NIGHT     = 12'h142,
    parameter logic [11:0] FENCE_RGB       = 12'h977,
    parameter int          FRAMES_PER_STEP = 4,
    parameter int          HOLD_STEPS      = 64
) (
    input  logic clk60MHz,
    input  logic rst_n,
    input  logic cycle_en,
    vga_if.in    in,
    vga_if.out   out,
    output logic night
);

    localparam logic [10:0] FX0       = 11'(FENCE_X0);
    localparam logic [10:0] FX1       = 11'(FENCE_X1);
    localparam logic [10:0] FY0       = 11'(FENCE_Y0);
    localparam logic [10:0] FY1       = 11'(FENCE_Y1);
    localparam logic [10:0] HOR_Y     = 11'(HORIZON_Y);
    localparam logic [7:0]  FPS_LAST  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {DAY, DUSK, NIGHT, DAWN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  frame_cnt;
    logic [7:0]  hold_q, hold_d;
    logic [11:0] sky_q, sky_d;
    logic [11:0] grass_q, grass_d;
    logic        vblnk_q;
    logic        frame_tick;
    logic        step_tick;
    logic [11:0] pix_rgb;

    // Move each 4-bit channel of cur one unit toward tgt.
    function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt);
        logic [11:0] res;
        res = cur;
        for (int i = 0; i < 3; i++) begin
            if (cur[i*4 +: 4] < tgt[i*4 +: 4])
                res[i*4 +: 4] = cur[i*4 +: 4] + 4'd1;
            else if (cur[i*4 +: 4] > tgt[i*4 +: 4])
                res[i*4 +: 4] = cur[i*4 +: 4] - 4'd1;
        end
        return res;
    endfunction

    assign frame_tick = in.vblnk & ~vblnk_q;
    assign step_tick  = frame_tick & cycle_en & (frame_cnt == FPS_LAST);
    assign night      = (state_q == NIGHT);

    // Frame counter and vblnk edge history.
    always_ff @(posedge clk60MHz) begin
        if (!rst_n) begin
            vblnk_q   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            vblnk_q <= in.vblnk;
            if (frame_tick && cycle_en)
                frame_cnt <= (frame_cnt == FPS_LAST) ? 8'd0 : frame_cnt + 8'd1;
        end
    end

    // Day/night state, hold counter and current colours.
    always_ff @(posedge clk60MHz) begin
        if (!rst_n) begin
            state_q <= DAY;
            hold_q  <= 8'd0;
            sky_q   <= SKY_DAY;
            grass_q <= GRASS_DAY;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sky_q   <= sky_d;
            grass_q <= grass_d;
        end
    end

    // Next-state logic; everything advances only on a step tick.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sky_d   = sky_q;
        grass_d = grass_q;
        if (step_tick) begin
            case (state_q)
                DAY, NIGHT: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = 8'd0;
                        state_d = (state_q == DAY) ? DUSK : DAWN;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                DUSK: begin
                    sky_d   = step_toward(sky_q, SKY_NIGHT);
                    grass_d = step_toward(grass_q, GRASS_NIGHT);
                    if (sky_d == SKY_NIGHT && grass_d == GRASS_NIGHT)
                        state_d = NIGHT;
                end
                DAWN: begin
                    sky_d   = step_toward(sky_q, SKY_DAY);
                    grass_d = step_toward(grass_q, GRASS_DAY);
                    if (sky_d == SKY_DAY && grass_d == GRASS_DAY)
                        state_d = DAY;
                end
                default: state_d = DAY;
            endcase
        end
    end

    // Pixel colour for the incoming coordinates.
    always_comb begin
        pix_rgb = 12'h000;
        if (in.hblnk || in.vblnk)
            pix_rgb = 12'h000;
        else if (in.hcount >= FX0 && in.hcount <= FX1 && in.vcount >= FY0 && in.vcount <= FY1)
            pix_rgb = FENCE_RGB;
        else if (in.vcount <= HOR_Y) begin
`ifdef BG_STARS_EN
            if (state_q == NIGHT && ((in.hcount[3:0] ^ in.vcount[4:1]) == 4'hA)
                && (in.hcount[6] == in.vcount[5]))
                pix_rgb = 12'hfff;
            else
                pix_rgb = sky_q;
`else
            pix_rgb = sky_q;
`endif
        end else
            pix_rgb = grass_q;
    end

    // One-clock output register keeping timing and colour aligned.
    always_ff @(posedge clk60MHz) begin
        if (!rst_n) begin
            out.vcount <= 11'd0;
            out.hcount <= 11'd0;
            out.vsync  <= 1'b0;
            out.hsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= 12'h000;
        end else begin
            out.vcount <= in.vcount;
            out.hcount <= in.hcount;
            out.vsync  <= in.vsync;
            out.hsync  <= in.hsync;
            out.vblnk  <= in.vblnk;
            out.hblnk  <= in.hblnk;
            out.rgb    <= pix_rgb;
        end
    end

endmodule

// File: tb/tb_draw_background_dyn.sv
// Bench for draw_background_dyn: directed pixel checks, then random frames
// with random cycle_en compared against a frame-level reference model.
module tb_draw_background_dyn;

    localparam int          FPS         = 2;
    localparam int          HOLD        = 3;
    localparam logic [11:0] SKY_DAY     = 12'hadf;
    localparam logic [11:0] SKY_NIGHT   = 12'h113;
    localparam logic [11:0] GRASS_DAY   = 12'h5c5;
    localparam logic [11:0] GRASS_NIGHT = 12'h142;

    logic clk60MHz = 1'b0;
    logic rst_n    = 1'b0;
    logic cycle_en = 1'b0;
    logic night;

    vga_if vin();
    vga_if vout();

    draw_background_dyn #(
        .FRAMES_PER_STEP(FPS),
        .HOLD_STEPS     (HOLD)
    ) dut (
        .clk60MHz(clk60MHz),
        .rst_n   (rst_n),
        .cycle_en(cycle_en),
        .in      (vin),
        .out     (vout),
        .night   (night)
    );

    always #5 clk60MHz = ~clk60MHz;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 day, 1 dusk, 2 night, 3 dawn.
    int ph, hold_m, fcnt_m;
    int sky_m[3];
    int grs_m[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ch(input logic [11:0] c, input int i);
        return int'((c >> (4 * i)) & 12'hf);
    endfunction

    function automatic logic [11:0] pk(input int c0, input int c1, input int c2);
        logic [3:0] a, b, c;
        a = c0[3:0];
        b = c1[3:0];
        c = c2[3:0];
        return {c, b, a};
    endfunction

    task automatic model_reset();
        ph = 0; hold_m = 0; fcnt_m = 0;
        for (int i = 0; i < 3; i++) begin
            sky_m[i] = ch(SKY_DAY, i);
            grs_m[i] = ch(GRASS_DAY, i);
        end
    endtask

    task automatic model_frame();
        int ts, tg;
        logic done;
        fcnt_m++;
        if (fcnt_m < FPS) return;
        fcnt_m = 0;
        if (ph == 0 || ph == 2) begin
            hold_m++;
            if (hold_m == HOLD) begin
                hold_m = 0;
                ph = ph + 1;
            end
        end else begin
            done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                ts = (ph == 1) ? ch(SKY_NIGHT, i) : ch(SKY_DAY, i);
                tg = (ph == 1) ? ch(GRASS_NIGHT, i) : ch(GRASS_DAY, i);
                if (sky_m[i] < ts) sky_m[i]++; else if (sky_m[i] > ts) sky_m[i]--;
                if (grs_m[i] < tg) grs_m[i]++; else if (grs_m[i] > tg) grs_m[i]--;
                if (sky_m[i] != ts || grs_m[i] != tg) done = 1'b0;
            end
            if (done) ph = (ph + 1) % 4;
        end
    endtask

    function automatic logic [11:0] model_rgb(input int h, input int v, input logic hb);
        if (hb) return 12'h000;
        if (h >= 497 && h <= 527 && v >= 384 && v <= 743) return 12'h977;
        if (v <= 668) begin
`ifdef BG_STARS_EN
            if (ph == 2 && (((h & 15) ^ ((v >> 1) & 15)) == 10) && (((h >> 6) & 1) == ((v >> 5) & 1)))
                return 12'hfff;
`endif
            return pk(sky_m[0], sky_m[1], sky_m[2]);
        end
        return pk(grs_m[0], grs_m[1], grs_m[2]);
    endfunction

    // Drive one active-region pixel and check the registered result.
    task automatic pixel(input string tag, input int h, input int v, input logic hb);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.vblnk  = 1'b0;
        vin.hsync  = hb;
        vin.vsync  = 1'b0;
        vin.rgb    = 12'($urandom);
        @(posedge clk60MHz); #1;
        check({tag, "_rgb"}, 32'(vout.rgb), 32'(model_rgb(h, v, hb)));
        check({tag, "_hcount"}, 32'(vout.hcount), 32'(h));
    endtask

    // One frame: vblnk rises (possible tick), a few blank lines, then pixels.
    task automatic frame(input logic en, input int npix);
        cycle_en   = en;
        vin.vblnk  = 1'b1;
        vin.hblnk  = 1'b1;
        vin.vsync  = 1'b1;
        @(posedge clk60MHz); #1;
        if (en) model_frame();
        repeat (2) begin
            @(posedge clk60MHz); #1;
        end
        check("vblnk_out", 32'(vout.vblnk), 32'd1);
        pixel("star_px", 10, 0, 1'b0);
        for (int k = 0; k < npix; k++)
            pixel("rand_px", $urandom_range(0, 1023), $urandom_range(0, 767), ($urandom_range(0, 7) == 0));
        check("night", 32'(night), 32'(ph == 2));
    endtask

    initial begin
        int guard;
        vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk  = 1'b0;  vin.vblnk  = 1'b0;  vin.rgb   = 12'h000;
        rst_n = 1'b0;
        vin.hcount = 11'd300; vin.vcount = 11'd200; vin.hsync = 1'b1;
        repeat (2) @(posedge clk60MHz);
        #1;
        check("rst_rgb", 32'(vout.rgb), 32'h0);
        check("rst_hcount", 32'(vout.hcount), 32'h0);
        check("rst_hsync", 32'(vout.hsync), 32'h0);
        check("rst_night", 32'(night), 32'h0);
        rst_n = 1'b1;
        model_reset();

        pixel("fence", 510, 400, 1'b0);
        check("fence_const", 32'(vout.rgb), 32'h977);
        pixel("horizon_sky", 100, 668, 1'b0);
        check("horizon_sky_const", 32'(vout.rgb), 32'hadf);
        pixel("below_grass", 100, 669, 1'b0);
        check("below_grass_const", 32'(vout.rgb), 32'h5c5);
        pixel("hblnk", 100, 669, 1'b1);
        check("hblnk_const", 32'(vout.rgb), 32'h000);
        pixel("fence_edge_x1", 527, 743, 1'b0);
        pixel("fence_out_x", 528, 743, 1'b0);
        pixel("fence_out_y", 497, 383, 1'b0);

        // Random frames with random freezes.
        for (int f = 0; f < 160; f++)
            frame(($urandom_range(0, 3) != 0), 3);

        // Run into DAWN, then reset in the middle of the fade.
        guard = 0;
        while (ph != 3 && guard < 300) begin
            frame(1'b1, 1);
            guard++;
        end
        check("reach_dawn", 32'(ph), 32'd3);
        frame(1'b1, 1);
        frame(1'b1, 1);
        rst_n = 1'b0;
        vin.vblnk = 1'b0; vin.hblnk = 1'b0;
        @(posedge clk60MHz); #1;
        rst_n = 1'b1;
        model_reset();
        check("midreset_night", 32'(night), 32'h0);
        pixel("midreset_sky", 100, 100, 1'b0);
        check("midreset_sky_const", 32'(vout.rgb), 32'hadf);

        for (int f = 0; f < 40; f++)
            frame(($urandom_range(0, 4) != 0), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
